pipe_hazard_ctrl: RTL

- Central stall/flush scheduler for the 5-stage RISC-V pipeline.
- Each cycle it decides whether PC and the IF/ID, ID/EX and EX/MEM registers load, hold or take a bubble.
- Inputs it weighs: load-use hazards, taken branches/jumps resolved in EX, instruction-memory not-ready, and a data-memory request/ready handshake.
- A small FSM tracks multi-cycle data-memory waits with a timeout; saturating counters record stall and flush cycles.

---
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: per-cycle PC/IF-ID/ID-EX/EX-MEM load/hold/bubble decisions.
// Control outputs are combinational (zero latency); FSM, wait timer, mem_err and perf counters are registered.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int OPCODE_WIDTH   = 7,
  parameter int CNT_WIDTH      = 16,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OPCODE_WIDTH-1:0]   id_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_branch_taken,
  input  logic                      imem_ready,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_write,
  output logic                      ifid_hold,
  output logic                      ifid_flush,
  output logic                      idex_hold,
  output logic                      idex_bubble,
  output logic                      exmem_hold,
  output logic                      mem_err,
  output logic [1:0]                ctrl_state,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ILL_2    = 2'b10,
    ILL_3    = 2'b11
  } state_e;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = OPCODE_WIDTH'(7'b0110111);
  localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC = OPCODE_WIDTH'(7'b0010111);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = OPCODE_WIDTH'(7'b1101111);
  localparam logic [OPCODE_WIDTH-1:0] OP_R     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_S     = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_B     = OPCODE_WIDTH'(7'b1100011);

  state_e               state_q, state_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 mem_err_q, mem_err_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic uses_rs1, uses_rs2, load_use;
  logic freeze, run_rows, flush_evt;

  assign uses_rs1 = (id_opcode != OP_LUI) && (id_opcode != OP_AUIPC) && (id_opcode != OP_JAL);
  assign uses_rs2 = (id_opcode == OP_R) || (id_opcode == OP_S) || (id_opcode == OP_B);
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));

  // Next state; freeze and run_rows select which output rule applies below.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    freeze     = 1'b0;
    run_rows   = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WW'(1);
        end else begin
          run_rows = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          run_rows   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WW'(MEM_TIMEOUT)) begin
          // Access abandoned: flag it and let the pipeline move on.
          mem_err_d  = 1'b1;
          run_rows   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    flush_evt   = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (freeze) begin
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
    end else if (run_rows) begin
      // Branch outranks load-use: the stalled instruction is squashed anyway.
      if (ex_branch_taken) begin
        pc_write    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        flush_evt   = 1'b1;
      end else if (load_use) begin
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end else if (!imem_ready) begin
        ifid_flush = 1'b1;
      end else begin
        pc_write = 1'b1;
      end
    end else begin
      pc_write = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err    = mem_err_q;
  assign ctrl_state = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
